// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection: load-use and branch operand stalls, IF/ID flush.
// Optional performance counters under HAZ_PERF_CNT_EN.
module hazard_detection_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RegRs,
  input  logic [4:0]       ID_RegRt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_Jump,
  input  logic             Branch_taken,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_RegRd,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_RegRd,
  input  logic             Ext_stall,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] Stall_cnt,
  output logic [CNT_W-1:0] Flush_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] remain;

  logic       ex_hit_s;
  logic       ex_hit_t;
  logic       ex_hit;
  logic       mem_hit_s;
  logic       mem_hit_t;
  logic       mem_hit;

  logic       ex_load_hit;
  logic       ex_alu_br_hit;
  logic       mem_load_br_hit;
  logic [1:0] n_req;

  logic       int_stall;
  logic       int_flush;
  logic       redirect;

  // Source-register matches; register 0 is never a real dependency
  always_comb begin
    ex_hit_s  = (EX_RegRd != 5'd0) && (EX_RegRd == ID_RegRs);
    ex_hit_t  = (EX_RegRd != 5'd0) && ID_UsesRt
              && (EX_RegRd == ID_RegRt);
    ex_hit    = ex_hit_s || ex_hit_t;
    mem_hit_s = (MEM_RegRd != 5'd0) && (MEM_RegRd == ID_RegRs);
    mem_hit_t = (MEM_RegRd != 5'd0) && ID_UsesRt
              && (MEM_RegRd == ID_RegRt);
    mem_hit   = mem_hit_s || mem_hit_t;
  end

  // Stall length required by the ID instruction (max over all cases)
  always_comb begin
    ex_load_hit     = EX_MemRead && ex_hit;
    ex_alu_br_hit   = ID_Branch && EX_RegWrite
                    && !EX_MemRead && ex_hit;
    mem_load_br_hit = ID_Branch && MEM_MemRead && mem_hit;
    n_req = 2'd0;
    if (ex_load_hit) begin
      n_req = ID_Branch ? 2'd2 : 2'd1;
    end else if (ex_alu_br_hit || mem_load_br_hit) begin
      n_req = 2'd1;
    end
  end

  // Internal stall/flush decision, before the global freeze
  always_comb begin
    redirect  = (ID_Branch && Branch_taken) || ID_Jump;
    int_stall = (state == HOLD)
             || ((state == RUN) && (n_req != 2'd0));
    int_flush = (state == RUN) && (n_req == 2'd0) && redirect;
  end

  // Output drive: reset, then global freeze, then internal stall/flush
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    if (rst_i) begin
      PC_Write    = 1'b1;
      IFID_Write  = 1'b1;
      IDEX_Bubble = 1'b0;
      IFID_Flush  = 1'b0;
    end else if (Ext_stall) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b0;
      IFID_Flush  = 1'b0;
    end else if (int_stall) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      IFID_Flush  = 1'b0;
    end else if (int_flush) begin
      IFID_Flush  = 1'b1;
    end
  end

  // Stall FSM: length is latched at detection and then counted down
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= RUN;
      remain <= 2'd0;
    end else if (!Ext_stall) begin
      unique case (state)
        RUN: begin
          if (n_req == 2'd2) begin
            state  <= HOLD;
            remain <= n_req - 2'd1;
          end
        end
        HOLD: begin
          remain <= remain - 2'd1;
          if (remain <= 2'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state  <= RUN;
          remain <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Performance counters, frozen during the global stall
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      Stall_cnt <= '0;
      Flush_cnt <= '0;
    end else if (!Ext_stall) begin
      if (int_stall) begin
        Stall_cnt <= Stall_cnt + 1'b1;
      end
      if (int_flush) begin
        Flush_cnt <= Flush_cnt + 1'b1;
      end
    end
  end
`else
  assign Stall_cnt = '0;
  assign Flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios plus
// randomized traffic against a stall-budget reference model.
module tb_hazard_detection_unit;

  localparam int CNT_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [4:0]       ID_RegRs;
  logic [4:0]       ID_RegRt;
  logic             ID_UsesRt;
  logic             ID_Branch;
  logic             ID_Jump;
  logic             Branch_taken;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [4:0]       EX_RegRd;
  logic             MEM_MemRead;
  logic [4:0]       MEM_RegRd;
  logic             Ext_stall;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic [CNT_W-1:0] Stall_cnt;
  logic [CNT_W-1:0] Flush_cnt;

  hazard_detection_unit #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ID_RegRs     (ID_RegRs),
    .ID_RegRt     (ID_RegRt),
    .ID_UsesRt    (ID_UsesRt),
    .ID_Branch    (ID_Branch),
    .ID_Jump      (ID_Jump),
    .Branch_taken (Branch_taken),
    .EX_MemRead   (EX_MemRead),
    .EX_RegWrite  (EX_RegWrite),
    .EX_RegRd     (EX_RegRd),
    .MEM_MemRead  (MEM_MemRead),
    .MEM_RegRd    (MEM_RegRd),
    .Ext_stall    (Ext_stall),
    .PC_Write     (PC_Write),
    .IFID_Write   (IFID_Write),
    .IDEX_Bubble  (IDEX_Bubble),
    .IFID_Flush   (IFID_Flush),
    .Stall_cnt    (Stall_cnt),
    .Flush_cnt    (Flush_cnt)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: number of stall cycles still owed, plus event counts
  int               pend;
  logic [CNT_W-1:0] m_scnt;
  logic [CNT_W-1:0] m_fcnt;
  logic             e_pc, e_ifid, e_bub, e_fl;
  logic             m_stall, m_flush;
  int               m_n;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (r == ID_RegRs) || (ID_UsesRt && r == ID_RegRt);
  endfunction

  function automatic int need();
    int n;
    n = 0;
    if (EX_MemRead && hit(EX_RegRd))
      n = ID_Branch ? 2 : 1;
    if (ID_Branch && EX_RegWrite && !EX_MemRead && hit(EX_RegRd)
        && n < 1)
      n = 1;
    if (ID_Branch && MEM_MemRead && hit(MEM_RegRd) && n < 1)
      n = 1;
    return n;
  endfunction

  task automatic model_eval();
    m_n     = need();
    m_stall = (pend > 0) || (m_n > 0);
    m_flush = !m_stall && ((ID_Branch && Branch_taken) || ID_Jump);
    if (rst_i) begin
      {e_pc, e_ifid, e_bub, e_fl} = 4'b1100;
    end else if (Ext_stall) begin
      {e_pc, e_ifid, e_bub, e_fl} = 4'b0000;
    end else if (m_stall) begin
      {e_pc, e_ifid, e_bub, e_fl} = 4'b0010;
    end else begin
      {e_pc, e_ifid, e_bub, e_fl} = {2'b11, 1'b0, m_flush};
    end
  endtask

  task automatic model_reset();
    pend   = 0;
    m_scnt = '0;
    m_fcnt = '0;
  endtask

  task automatic model_clock();
    if (!rst_i && !Ext_stall) begin
      if (pend > 0) begin
        pend--;
      end else if (m_n > 0) begin
        pend = m_n - 1;
      end
`ifdef HAZ_PERF_CNT_EN
      if (m_stall) m_scnt = m_scnt + 1'b1;
      if (m_flush) m_fcnt = m_fcnt + 1'b1;
`endif
    end
  endtask

  task automatic cmp_all(input string tag);
    model_eval();
    chk({tag, ".pc"},   PC_Write,    e_pc);
    chk({tag, ".ifid"}, IFID_Write,  e_ifid);
    chk({tag, ".bub"},  IDEX_Bubble, e_bub);
    chk({tag, ".fl"},   IFID_Flush,  e_fl);
    chk({tag, ".sc"},   Stall_cnt,   m_scnt);
    chk({tag, ".fc"},   Flush_cnt,   m_fcnt);
  endtask

  // Compare mid-cycle, advance the model, move to the next negedge
  task automatic step(input string tag);
    #1;
    cmp_all(tag);
    model_clock();
    @(negedge clk_i);
  endtask

  task automatic idle();
    ID_RegRs     = 5'd0;
    ID_RegRt     = 5'd0;
    ID_UsesRt    = 1'b0;
    ID_Branch    = 1'b0;
    ID_Jump      = 1'b0;
    Branch_taken = 1'b0;
    EX_MemRead   = 1'b0;
    EX_RegWrite  = 1'b0;
    EX_RegRd     = 5'd0;
    MEM_MemRead  = 1'b0;
    MEM_RegRd    = 5'd0;
    Ext_stall    = 1'b0;
  endtask

  logic [CNT_W-1:0] s0, f0;

  initial begin
    idle();
    rst_i = 1'b1;
    model_reset();
    #2;
    cmp_all("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    step("idle");

    // Load-use, one bubble
    EX_MemRead = 1'b1; EX_RegRd = 5'd5; ID_RegRs = 5'd5;
    #1 chk("lu_bub", IDEX_Bubble, 1'b1);
    chk("lu_pc", PC_Write, 1'b0);
    step("lu");
    idle();
    #1 chk("lu_after", PC_Write, 1'b1);
    step("lu_after");

    // Register 0 never hazards
    EX_MemRead = 1'b1; EX_RegRd = 5'd0; ID_RegRs = 5'd0;
    #1 chk("r0_bub", IDEX_Bubble, 1'b0);
    step("r0");

    // Load then branch: two stalls, second from HOLD
    idle();
    s0 = m_scnt;
    EX_MemRead = 1'b1; EX_RegRd = 5'd8; ID_Branch = 1'b1;
    ID_RegRt = 5'd8; ID_UsesRt = 1'b1;
    step("lb1");
    EX_MemRead = 1'b0; EX_RegRd = 5'd0;
    #1 chk("lb_hold", IDEX_Bubble, 1'b1);
    step("lb2");
    ID_Branch = 1'b0;
    #1 chk("lb_done", IDEX_Bubble, 1'b0);
`ifdef HAZ_PERF_CNT_EN
    chk("lb_scnt", Stall_cnt, s0 + 2);
`endif
    step("lb3");

    // ALU then branch: one stall, then taken-branch flush
    idle();
    f0 = m_fcnt;
    EX_RegWrite = 1'b1; EX_RegRd = 5'd3; ID_Branch = 1'b1;
    ID_RegRs = 5'd3;
    step("ab1");
    EX_RegWrite = 1'b0; EX_RegRd = 5'd0; Branch_taken = 1'b1;
    #1 chk("ab_flush", IFID_Flush, 1'b1);
    chk("ab_pc", PC_Write, 1'b1);
    step("ab2");
    idle();
    #1 chk("ab_noflush", IFID_Flush, 1'b0);
`ifdef HAZ_PERF_CNT_EN
    chk("ab_fcnt", Flush_cnt, f0 + 1);
`endif
    step("ab3");

    // Global freeze in the middle of a two-cycle stall
    EX_MemRead = 1'b1; EX_RegRd = 5'd9; ID_Branch = 1'b1;
    ID_RegRs = 5'd9;
    step("ex1");
    idle();
    Ext_stall = 1'b1;
    s0 = m_scnt;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ex_frz_bub", IDEX_Bubble, 1'b0);
      chk("ex_frz_pc", PC_Write, 1'b0);
      step("ex_frz");
    end
    chk("ex_frz_sc", Stall_cnt, s0);
    Ext_stall = 1'b0;
    #1 chk("ex_resume", IDEX_Bubble, 1'b1);
    step("ex2");
    #1 chk("ex_done", IDEX_Bubble, 1'b0);
    step("ex3");

    // Asynchronous reset while in HOLD
    EX_MemRead = 1'b1; EX_RegRd = 5'd4; ID_Branch = 1'b1;
    ID_RegRs = 5'd4;
    step("rh1");
    idle();
    #3 rst_i = 1'b1;
    model_reset();
    #1;
    chk("rh_pc", PC_Write, 1'b1);
    chk("rh_bub", IDEX_Bubble, 1'b0);
    cmp_all("rh_rst");
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    @(negedge clk_i);
    #1 chk("rh_after", IDEX_Bubble, 1'b0);
    step("rh_after");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ID_RegRs     = 5'($urandom_range(0, 3));
      ID_RegRt     = 5'($urandom_range(0, 3));
      ID_UsesRt    = 1'($urandom_range(0, 1));
      ID_Branch    = ($urandom_range(0, 2) == 0);
      ID_Jump      = ($urandom_range(0, 5) == 0);
      Branch_taken = 1'($urandom_range(0, 1));
      EX_MemRead   = ($urandom_range(0, 2) == 0);
      EX_RegWrite  = 1'($urandom_range(0, 1));
      EX_RegRd     = 5'($urandom_range(0, 3));
      MEM_MemRead  = ($urandom_range(0, 2) == 0);
      MEM_RegRd    = 5'($urandom_range(0, 3));
      Ext_stall    = ($urandom_range(0, 4) == 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule
